uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receive stage directly upstream of the UART transmitter.
- Deserialises 8N1 frames on rs232_rx and drives the baud generator through bps_start / clk_bps.
- Presents each good byte on rx_data and signals it with rx_int, which the transmitter edge-detects to start an echo.
- Adds start-bit confirmation and stop-bit checking so that false starts and framing errors never trigger the transmitter.

Parameters:
- SYNC_STAGES, 3, number of flops synchronising rs232_rx to clk; legal range 2..4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- rs232_rx  input  1  asynchronous serial line; idle high
- clk_bps  input  1  one-clk pulse at each bit centre from the baud generator; first pulse half a bit after bps_start rises, then one per bit period
- bps_start  output  1  high requests the baud generator to run; low holds and clears it
- rx_data  output  8  last correctly received byte
- rx_int  output  1  one-clk strobe, good byte available; its falling edge triggers the transmitter
- frame_err  output  1  one-clk strobe, stop bit sampled low
- rx_busy  output  1  high while a frame is in progress (WAIT_START through STOP)

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk; the rising edge on which rst_n is sampled low returns the block to reset state. Asserting reset mid-frame aborts the frame.
- Reset values: all outputs 0, state IDLE, bit counter 0, shift register 0. Synchroniser flops reset to 1 so that no false edge appears after reset.
- Synchroniser: rs232_rx passes through SYNC_STAGES flops; rxs is the last stage. One further flop rxs_d gives the previous value.
- In all states, clk_bps is acted on only in the cycle it is high. clk_bps pulses in IDLE or DONE are ignored.
- IDLE: bps_start = 0. When rxs_d = 1 and rxs = 0 (falling edge), go to WAIT_START on the next clk and set bps_start = 1.
- WAIT_START (first clk_bps pulse = start-bit centre):
  - rxs = 0: confirmed start; go to DATA, counter = 0.
  - rxs = 1: false start; go to DONE. No strobe is generated.
- DATA: on each clk_bps pulse, shift right with rxs into bit 7 (LSB first) and increment the counter. On the 8th pulse (counter was 7) go to STOP.
- STOP (next clk_bps pulse = stop-bit centre):
  - rxs = 1: on the next clk, rx_data = shift register and rx_int = 1 for exactly one cycle.
  - rxs = 0: on the next clk, frame_err = 1 for one cycle; rx_data keeps its old value and rx_int stays 0.
  - In both cases go to DONE.
- DONE: bps_start = 0 for exactly one clk, then go to IDLE. This guarantees the generator sees a low gap between frames.
- Timing:
  - bps_start rises on the clk after the falling edge is detected on rxs.
  - It falls on the clk after the stop-bit (or false-start) sample.
  - Stop-bit sample to rx_int/frame_err is 1 clk.
- Falling edges on rxs while the state is not IDLE are ignored. The stop-bit sample occurs with the line high, so a new start edge after DONE is detected normally.
- rx_data changes only in the same cycle that rx_int is asserted. It is stable at all other times, including through the transmitter's edge-detect latency.
- rx_busy = 1 in WAIT_START, DATA and STOP; 0 otherwise.

Test Plan:
- Reset with rs232_rx held high, clk_bps pulsed randomly for 100 clks -> bps_start, rx_int, frame_err, rx_busy all stay 0; rx_data = 8'h00.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with a clk_bps model 16 clks/bit -> bps_start high from start edge+SYNC_STAGES+1 clks; rx_int single-cycle pulse 1 clk after stop sample; rx_data = 8'hA5; frame_err = 0.
- Low glitch of 3 clks on rs232_rx, line high at first clk_bps -> bps_start pulses high then low via DONE; rx_int and frame_err stay 0; rx_data unchanged.
- Frame 0x3C with stop bit driven 0 -> frame_err one-cycle pulse; rx_int = 0; rx_data retains the previous 8'hA5; next good frame 0x81 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap beyond the stop bit -> two rx_int strobes; rx_data = 8'h00 then 8'hFF; bps_start low for exactly 1 clk between frames.
- rst_n driven low during DATA bit 4 of 0x5A, released -> all outputs 0 on the next clk; no rx_int; a subsequent frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART 8N1 receive stage with start confirmation and stop-bit check
//
// Purpose: deserialises 8N1 frames from rs232_rx, running an external baud
// generator through bps_start/clk_bps. A good byte is presented on rx_data
// with a one-cycle rx_int strobe. False starts and bad stop bits never strobe rx_int.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rs232_rx   asynchronous serial line, idle high
//   clk_bps    one-clk pulse at each bit centre from the baud generator
//   bps_start  run request to the baud generator (low holds and clears it)
//   rx_data    last correctly received byte
//   rx_int     one-clk strobe, good byte available
//   frame_err  one-clk strobe, stop bit sampled low
//   rx_busy    frame in progress
module uart_rx_frame #(
   parameter int SYNC_STAGES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs232_rx,
   input  logic       clk_bps,
   output logic       bps_start,
   output logic [7:0] rx_data,
   output logic       rx_int,
   output logic       frame_err,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs_d_q, rxs_d_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_int_q, rx_int_d;
   logic                   frame_err_q, frame_err_d;
   logic                   bps_start_q, bps_start_d;
   logic                   rx_busy_q, rx_busy_d;
   logic                   rxs;

   assign rxs = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], rs232_rx};
      rxs_d_d     = rxs;
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_int_d    = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rxs_d_q && !rxs) begin
               state_d = S_WAIT_START;
            end
         end
         S_WAIT_START: begin
            // First pulse lands mid start bit: still low confirms a real start.
            if (clk_bps) begin
               if (!rxs) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DATA: begin
            // LSB arrives first, so shift right and insert at the top.
            if (clk_bps) begin
               shift_d   = {rxs, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (clk_bps) begin
               if (rxs) begin
                  rx_data_d = shift_q;
                  rx_int_d  = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // One forced low cycle on bps_start so the generator restarts cleanly.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      bps_start_d = (state_d == S_WAIT_START) || (state_d == S_DATA) || (state_d == S_STOP);
      rx_busy_d   = bps_start_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync_q      <= '1;
         rxs_d_q     <= 1'b1;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_int_q    <= 1'b0;
         frame_err_q <= 1'b0;
         bps_start_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         rxs_d_q     <= rxs_d_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_int_q    <= rx_int_d;
         frame_err_q <= frame_err_d;
         bps_start_q <= bps_start_d;
         rx_busy_q   <= rx_busy_d;
      end
   end

   assign bps_start = bps_start_q;
   assign rx_data   = rx_data_q;
   assign rx_int    = rx_int_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

   localparam int S = 3;

   logic       clk;
   logic       rst_n;
   logic       rs232_rx;
   logic       clk_bps;
   logic       bps_start;
   logic [7:0] rx_data;
   logic       rx_int;
   logic       frame_err;
   logic       rx_busy;

   uart_rx_frame #(.SYNC_STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs232_rx  (rs232_rx),
      .clk_bps   (clk_bps),
      .bps_start (bps_start),
      .rx_data   (rx_data),
      .rx_int    (rx_int),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: line history, pulse index within a frame, collected bits.
   logic [7:0] hist = 8'hFF;
   logic       active = 1'b0;
   logic       gap = 1'b0;
   int         npulse = 0;
   logic [7:0] mbyte = 8'h00;
   logic       exp_bps = 1'b0;
   logic       exp_int = 1'b0;
   logic       exp_ferr = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int         ncount = 0;
   logic       started = 1'b0;

   initial forever begin
      logic now, prev;
      @(posedge clk);
      now  = hist[S-1];
      prev = hist[S];
      if (!rst_n) begin
         exp_bps = 0; exp_int = 0; exp_ferr = 0; exp_data = 8'h00;
         active = 0; gap = 0; npulse = 0; hist = 8'hFF;
      end else begin
         exp_int  = 0;
         exp_ferr = 0;
         if (gap) begin
            gap = 0;
         end else if (!active) begin
            if (prev && !now) begin
               active = 1;
               npulse = 0;
            end
         end else if (clk_bps) begin
            if (npulse == 0) begin
               if (now) begin active = 0; gap = 1; end
            end else if (npulse <= 8) begin
               mbyte[npulse-1] = now;
            end else begin
               if (now) begin exp_data = mbyte; exp_int = 1; end
               else exp_ferr = 1;
               active = 0;
               gap = 1;
            end
            npulse++;
         end
         exp_bps = active;
         hist = {hist[6:0], rs232_rx};
      end
      ncount++;
      started = 1;
   end

   // Baud generator: first pulse 8 clks after run request, then every 16; random noise when held.
   int gcnt = 0;
   initial begin
      clk_bps = 1'b0;
      forever begin
         @(negedge clk);
         if (bps_start) begin
            clk_bps = ((gcnt % 16) == 7);
            gcnt++;
         end else begin
            gcnt = 0;
            clk_bps = ($urandom_range(0, 7) == 0);
         end
      end
   end

   // Per-cycle compare and event bookkeeping.
   int         int_cnt = 0;
   int         ferr_cnt = 0;
   int         rise_cnt = 0;
   int         last_rise = 0;
   logic       bps_prev = 1'b0;
   logic [7:0] got_q[$];

   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("bps_start", {31'd0, bps_start}, {31'd0, exp_bps});
         chk("rx_busy", {31'd0, rx_busy}, {31'd0, exp_bps});
         chk("rx_int", {31'd0, rx_int}, {31'd0, exp_int});
         chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
         chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
         if (rx_int) begin
            int_cnt++;
            got_q.push_back(rx_data);
         end
         if (frame_err) ferr_cnt++;
         if (bps_start && !bps_prev) begin
            rise_cnt++;
            last_rise = ncount;
         end
         bps_prev = bps_start;
      end
   end

   int t_low = 0;

   task automatic idle(input int n);
      rs232_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rs232_rx = bits[i];
         if (i == 0) t_low = ncount;
         repeat (16) @(negedge clk);
      end
   endtask

   initial begin
      int i0, f0, r0, good_n, err_n;
      logic [9:0] bits;
      rs232_rx = 1'b1;
      rst_n    = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      idle(100);
      chk("reset rx_data", {24'd0, rx_data}, 32'h00);
      chk("reset no bps rise", rise_cnt, 0);
      chk("reset no rx_int", int_cnt, 0);

      // Good 0xA5
      send_frame(8'hA5, 1'b1);
      idle(20);
      chk("A5 rx_data", {24'd0, rx_data}, 32'hA5);
      chk("A5 rx_int count", int_cnt, 1);
      chk("A5 no frame_err", ferr_cnt, 0);
      chk("A5 bps latency", last_rise - t_low, S + 1);

      // Short low glitch: false start
      i0 = int_cnt; f0 = ferr_cnt; r0 = rise_cnt;
      rs232_rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(60);
      chk("glitch bps pulse", rise_cnt - r0, 1);
      chk("glitch no rx_int", int_cnt - i0, 0);
      chk("glitch no frame_err", ferr_cnt - f0, 0);
      chk("glitch rx_data kept", {24'd0, rx_data}, 32'hA5);

      // Bad stop bit, then a good frame
      send_frame(8'h3C, 1'b0);
      idle(20);
      chk("3C frame_err", ferr_cnt - f0, 1);
      chk("3C no rx_int", int_cnt - i0, 0);
      chk("3C rx_data kept", {24'd0, rx_data}, 32'hA5);
      send_frame(8'h81, 1'b1);
      idle(20);
      chk("81 rx_data", {24'd0, rx_data}, 32'h81);

      // Back-to-back 0x00, 0xFF
      got_q.delete();
      r0 = rise_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      chk("b2b strobes", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("b2b first", {24'd0, got_q[0]}, 32'h00);
         chk("b2b second", {24'd0, got_q[1]}, 32'hFF);
      end
      chk("b2b bps rises", rise_cnt - r0, 2);

      // Reset in the middle of data bit 4 of 0x5A
      i0 = int_cnt;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rs232_rx = bits[i];
         repeat ((i == 4) ? 12 : 16) @(negedge clk);
      end
      rs232_rx = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst bps_start", {31'd0, bps_start}, 32'd0);
      chk("rst rx_busy", {31'd0, rx_busy}, 32'd0);
      chk("rst rx_data", {24'd0, rx_data}, 32'h00);
      rst_n = 1'b1;
      idle(200);
      chk("rst no rx_int", int_cnt - i0, 0);
      send_frame(8'h5A, 1'b1);
      idle(20);
      chk("5A after reset", {24'd0, rx_data}, 32'h5A);

      // Randomized traffic
      i0 = int_cnt; f0 = ferr_cnt; good_n = 0; err_n = 0;
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            rs232_rx = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            idle(40);
         end else if (kind == 2) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0);
            err_n++;
            idle($urandom_range(2, 20));
         end else begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            good_n++;
            idle($urandom_range(0, 10));
         end
      end
      idle(40);
      chk("random good count", int_cnt - i0, good_n);
      chk("random error count", ferr_cnt - f0, err_n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
